// File: rtl/grf_dump_pkg.sv
// Shared types and default sizing for the GRF dump engine.
// The optional checksum beat is enabled with `define GRF_DUMP_CHECKSUM_EN.
package grf_dump_pkg;

    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_CSUM,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [AW_DEF-1:0] idx;
        logic [DW_DEF-1:0] data;
        logic              last;
    } beat_t;

endpackage

// File: rtl/grf_dump.sv
// Walks GRF indices 0..NREG-1 through one read port and streams {index, data} beats.
// `define GRF_DUMP_CHECKSUM_EN appends an XOR-of-all-words beat before completion.
module grf_dump
    import grf_dump_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_idx,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
`ifdef GRF_DUMP_CHECKSUM_EN
    localparam logic LAST_ON_DATA = 1'b0;
`else
    localparam logic LAST_ON_DATA = 1'b1;
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] out_idx_q, out_idx_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
`ifdef GRF_DUMP_CHECKSUM_EN
    logic [DW-1:0] csum_q, csum_d;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            out_idx_q  <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
`ifdef GRF_DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_idx_q  <= out_idx_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
`ifdef GRF_DUMP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
`ifdef GRF_DUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        rd_addr    = '0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
`ifdef GRF_DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_FETCH: begin
                rd_addr    = idx_q;
                out_idx_d  = idx_q;
                out_data_d = rd_data;
                out_last_d = LAST_ON_DATA && (idx_q == LAST_IDX);
`ifdef GRF_DUMP_CHECKSUM_EN
                csum_d     = csum_q ^ rd_data;
`endif
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
`ifdef GRF_DUMP_CHECKSUM_EN
                        // csum_q already includes the last word, folded in during its FETCH.
                        state_d    = ST_CSUM;
                        out_idx_d  = '0;
                        out_data_d = csum_q;
                        out_last_d = 1'b1;
`else
                        state_d    = ST_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
`ifdef GRF_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_idx  = out_idx_q;
    assign out_data = out_data_q;
    assign out_last = out_last_q;

endmodule

// File: tb/tb_grf_dump.sv
// Scoreboard bench for grf_dump: a GRF model feeds the read port, expected beats
// are queued at each start and popped as the DUT hands them off.
`timescale 1ns/1ps
module tb_grf_dump;
    import grf_dump_pkg::*;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
`ifdef GRF_DUMP_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] grf [NREG];
    beat_t         sb [$];
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    // Register 0 is hardwired to zero, as in the real GRF.
    assign rd_data = (rd_addr == '0) ? '0 : grf[rd_addr];

    grf_dump #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic load_grf(input logic [DW-1:0] base);
        for (int i = 0; i < NREG; i++) grf[i] = base + DW'(i);
    endtask

    task automatic push_dump();
        beat_t         b;
        logic [DW-1:0] x = '0;
        for (int i = 0; i < NREG; i++) begin
            b.idx  = AW'(i);
            b.data = (i == 0) ? '0 : grf[i];
            b.last = (i == NREG - 1) && !CSUM;
            x      = x ^ b.data;
            sb.push_back(b);
        end
        if (CSUM) begin
            b.idx  = '0;
            b.data = x;
            b.last = 1'b1;
            sb.push_back(b);
        end
    endtask

    // Pulses start and checks the FETCH cycle that follows it.
    task automatic pulse_start(input string name);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || rd_addr !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s fetch0: valid=%b busy=%b rd_addr=%0d done=%b, want 0 1 0 0",
                     name, out_valid, busy, rd_addr, done);
        end
    endtask

    // Consumes beats against the scoreboard. Negative arguments disable the option.
    task automatic drain(input string name, input int stall_idx, input int stall_len,
                         input int pulse_at, input int abort_idx, input int snap_idx,
                         input int exp_done_c);
        int    stall_left = stall_len;
        int    last_hs = -10;
        int    beats = 0;
        bit    fin = 1'b0;
        bit    pend_wr = 1'b0;
        beat_t e;
        out_ready = 1'b1;
        for (int c = 0; c < 400 && !fin; c++) begin
            if (pend_wr) begin
                @(posedge clk);
                #1;
                grf[snap_idx] = 32'hDEAD_BEEF;
                pend_wr = 1'b0;
            end
            @(negedge clk);
            start = (c == pulse_at);
            if (done) begin
                checks++;
                if (c != exp_done_c || c != last_hs + 1 || busy !== 1'b0 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done: at cycle %0d (last handshake %0d) busy=%b valid=%b, want cycle %0d busy=0 valid=0",
                             name, c, last_hs, busy, out_valid, exp_done_c);
                end
                fin = 1'b1;
            end else if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra beat: idx=%0d data=%h, want no beat", name, out_idx, out_data);
                    fin = 1'b1;
                end else begin
                    e = sb[0];
                    if (out_idx !== e.idx || out_data !== e.data || out_last !== e.last || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s beat: idx=%0d data=%h last=%b busy=%b, want idx=%0d data=%h last=%b busy=1",
                                 name, out_idx, out_data, out_last, busy, e.idx, e.data, e.last);
                    end
                    if (abort_idx >= 0 && int'(out_idx) == abort_idx && !out_last) begin
                        out_ready = 1'b0;
                        #2 reset = 1'b0;
                        #1;
                        checks++;
                        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_idx !== '0 ||
                            out_data !== '0 || out_last !== 1'b0 || rd_addr !== '0) begin
                            errors++;
                            $display("FAIL %s async reset: valid=%b busy=%b done=%b idx=%0d data=%h last=%b rd_addr=%0d, want all 0",
                                     name, out_valid, busy, done, out_idx, out_data, out_last, rd_addr);
                        end
                        @(negedge clk);
                        reset = 1'b1;
                        out_ready = 1'b1;
                        sb.delete();
                        return;
                    end else if (stall_left > 0 && int'(out_idx) == stall_idx && !out_last) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                        void'(sb.pop_front());
                        beats++;
                        last_hs = c;
                        if (snap_idx >= 0 && int'(out_idx) == snap_idx && beats == snap_idx + 1) pend_wr = 1'b1;
                    end
                end
            end
        end
        start = 1'b0;
        checks++;
        if (!fin || sb.size() != 0 || beats != NREG + int'(CSUM)) begin
            errors++;
            $display("FAIL %s completion: finished=%b beats=%0d left=%0d, want finished=1 beats=%0d left=0",
                     name, fin, beats, sb.size(), NREG + int'(CSUM));
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s idle after: done=%b valid=%b busy=%b, want 0 0 0", name, done, out_valid, busy);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            out_idx !== '0 || out_data !== '0 || rd_addr !== '0) begin
            errors++;
            $display("FAIL reset values: valid=%b last=%b busy=%b done=%b idx=%0d data=%h rd_addr=%0d, want all 0",
                     out_valid, out_last, busy, done, out_idx, out_data, rd_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle: busy=%b valid=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_full_dump();
        load_grf(32'h1000);
        push_dump();
        pulse_start("full");
        drain("full", -1, 0, -1, -1, -1, 2 * NREG - 1 + int'(CSUM));
    endtask

    task automatic test_back_pressure();
        push_dump();
        pulse_start("stall");
        drain("stall", 3, 5, -1, -1, -1, 2 * NREG - 1 + int'(CSUM) + 5);
    endtask

    task automatic test_snapshot();
        push_dump();
        pulse_start("snap");
        drain("snap", -1, 0, -1, -1, 5, 2 * NREG - 1 + int'(CSUM));
        checks++;
        if (grf[5] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL snap write: grf5=%h, want deadbeef", grf[5]);
        end
        push_dump();
        pulse_start("redump");
        drain("redump", -1, 0, -1, -1, -1, 2 * NREG - 1 + int'(CSUM));
    endtask

    task automatic test_start_ignored();
        load_grf(32'h1000);
        push_dump();
        pulse_start("restart");
        drain("restart", -1, 0, 10, -1, -1, 2 * NREG - 1 + int'(CSUM));
    endtask

    task automatic test_reset_mid_dump();
        push_dump();
        pulse_start("abort");
        drain("abort", -1, 0, -1, 10, -1, 0);
        push_dump();
        pulse_start("after_abort");
        drain("after_abort", -1, 0, -1, -1, -1, 2 * NREG - 1 + int'(CSUM));
    endtask

`ifdef GRF_DUMP_CHECKSUM_EN
    task automatic test_checksum();
        load_grf(32'h0);
        push_dump();
        checks++;
        if (sb[NREG].data !== 32'h0 || sb[NREG].last !== 1'b1 || sb[NREG-1].last !== 1'b0) begin
            errors++;
            $display("FAIL csum expect: data=%h last=%b last31=%b, want 0 1 0",
                     sb[NREG].data, sb[NREG].last, sb[NREG-1].last);
        end
        pulse_start("csum");
        drain("csum", -1, 0, -1, -1, -1, 2 * NREG);
    endtask
`endif

    initial begin
        test_reset();
        test_full_dump();
        test_back_pressure();
        test_snapshot();
        test_start_ignored();
        test_reset_mid_dump();
`ifdef GRF_DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grf_dump.md
# grf_dump

Sequential read-out engine for the 32×32 general register file. On a `start` pulse it walks register indices 0..31 through one GRF read port. It captures each word and streams it as an `{index, data}` beat over a valid/ready interface to the trace/debug sink. It sits beside the CPU datapath, drives the GRF read address itself, and never writes the register file.

## Interface
Parameters:
- `NREG`, 32: number of registers walked (indices 0..NREG-1).
- `AW`, 5: register index width.
- `DW`, 32: register data width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; the block is in reset while `reset`=0.
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- `rd_addr`  out  AW  GRF read address (A1/A2-style port, combinational read).
- `rd_data`  in  DW  GRF read data for `rd_addr`, valid in the same cycle.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  sink accepts beat.
- `out_idx`  out  AW  register index of the beat.
- `out_data`  out  DW  captured register value.
- `out_last`  out  1  final beat of the dump.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the dump completes.

## Operation
- States: IDLE, FETCH, SEND, DONE (plus CSUM with the macro below).
- IDLE: `rd_addr`=0 and `busy`=0. `start`=1 moves to FETCH with index counter `idx`=0.
- FETCH (1 cycle):
  - `rd_addr`=`idx`.
  - `rd_data` is registered into `out_data` and `idx` into `out_idx`.
  - Moves to SEND.
- SEND:
  - `out_valid`=1. `out_idx`, `out_data` and `out_last` are held stable until the handshake.
  - Handshake is `out_valid & out_ready` at a rising edge. On handshake with `idx`<NREG-1: `idx`+1, go to FETCH. On `idx`=NREG-1: go to DONE (or CSUM).
- DONE (1 cycle): `done`=1, `busy`=0 in this cycle, return to IDLE.
- `out_last`=1 only on the beat carrying index NREG-1, or on the checksum beat when enabled.
- Snapshot semantics are per register. Each value is the GRF content at its FETCH cycle. GRF writes after that cycle are not reflected. A same-cycle write to the fetched index shows the old value, because the GRF writes on the edge.
- Register 0 is dumped like any other; its value is whatever the GRF returns (0).
- `start` while not IDLE is ignored. No queueing.
- `idx` counts 0..NREG-1 without wrap. Its width is AW, and NREG ≤ 2^AW is required.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, `out_idx`=0, `out_data`=0, `rd_addr`=0, state IDLE.
- Latency:
  - `start` at edge N: FETCH in cycle N+1, first `out_valid` in N+2.
  - Minimum 2 cycles per register, so a full dump takes 2·NREG cycles with `out_ready` held at 1. `done` follows in the cycle after the last handshake.
- Back-pressure: `out_ready`=0 stalls in SEND indefinitely with outputs frozen.
- `out_ready` has no combinational path to `out_valid`.
- Reset asserted mid-dump clears all outputs immediately (asynchronous). No partial `done`. The next `start` restarts at index 0.

## Configuration
- `GRF_DUMP_CHECKSUM_EN` defined:
  - After index NREG-1 is accepted, state CSUM emits one extra beat. `out_idx`=0, `out_data` = XOR of all NREG captured words, `out_last`=1.
  - The index NREG-1 beat then has `out_last`=0.
  - DONE follows the CSUM handshake, so the dump takes 2·NREG+1 cycles minimum.
- Undefined: no CSUM state and no accumulator. The index NREG-1 beat carries `out_last`=1.

## Structure
- Shared package: state encoding enum (IDLE/FETCH/SEND/CSUM/DONE), default `NREG`/`AW`/`DW` constants, and the beat struct `{idx, data, last}`.
- No sub-module is needed. The XOR accumulator is inline logic guarded by the macro.

## Test plan
- Reset then idle: GRF loaded with $i = 0x1000+i, `out_ready`=1, `start` pulse → 32 beats (`out_idx` 0..31, data 0x1000..0x101F; reg 0 reads 0). `out_last` only on idx 31. `done` in the cycle after the final handshake. 64 cycles from first FETCH.
- Back-pressure: `out_ready` low for 5 cycles on idx 3 → `out_idx`/`out_data` held at 3/0x1003. Beat accepted once. Next beat is idx 4.
- Snapshot: GRF writes $5 ← 0xDEADBEEF after idx 5 is captured → beat 5 shows 0x1005. A re-dump shows 0xDEADBEEF.
- `start` pulsed again during a dump → ignored. Exactly 32 beats and one `done`.
- `reset` driven low during idx 10 SEND → `out_valid`/`busy` drop at once. A new `start` begins at idx 0.
- With `GRF_DUMP_CHECKSUM_EN`, all $i = i → 33rd beat has `out_data` = 0 (XOR of 0..31) and `out_last`=1. Beat 31 has `out_last`=0.
